pc_ras_unit: RTL and testbench
==============================

Name: pc_ras_unit

Overview:
- Parametrised next-generation fetch PC unit with a configurable address width and reset vector.
- Selects the next PC from sequential, jump, jump-and-link, branch, jump-register, return and flush sources.
- Contains a circular return-address stack (RAS) that predicts return targets and flags mispredictions.
- Sits at the fetch stage: drives the instruction-memory address and consumes control and register data from decode.

Parameters:
ADDR_W, 32, PC width in bits; must be >= 28.
PC_INIT, 0, PC value loaded on reset.
RAS_DEPTH, 4, number of RAS entries; power of two, >= 2.
RAS_CNT_W, $clog2(RAS_DEPTH)+1, width of the RAS occupancy count.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
pc_en  in  1  PC advance enable; 0 = stall
flush_en  in  1  redirect to flush_vec; overrides pc_en
flush_vec  in  ADDR_W  flush/exception target
pc_src  in  3  0 SEQ, 1 J, 2 JAL, 3 BR, 4 JR, 5 RET; 6-7 treated as SEQ
br_taken  in  1  branch condition; used only when pc_src=BR
rdat1  in  ADDR_W  register-file $rs value (JR/RET target)
immediate26  in  26  jump index
immediate16  in  16  branch offset, sign-extended internally
imemaddr  out  ADDR_W  current PC
pc_plus_4  out  ADDR_W  PC+4 (link value)
ras_top  out  ADDR_W  current top-of-stack; 0 when empty
ras_empty  out  1  RAS holds no entries
ras_count  out  RAS_CNT_W  RAS occupancy, 0..RAS_DEPTH
ras_miss  out  1  registered one-cycle misprediction pulse

Behaviour:
- Reset (RST high at a rising edge):
  - PC <= PC_INIT.
  - RAS count <= 0 and write pointer <= 0.
  - ras_miss <= 0.
  - Therefore imemaddr = PC_INIT, ras_empty = 1, ras_count = 0 and ras_top = 0.
  - Reset wins over every other input, including flush_en.
- pc_plus_4 = PC + 4, computed modulo 2^ADDR_W.
- Next PC:
  - Priority: flush_en > !pc_en (hold) > pc_src.
  - SEQ: PC+4.
  - J / JAL: {pc_plus_4[ADDR_W-1:28], immediate26, 2'b00}.
  - BR: if br_taken, PC+4 + (sext(immediate16) << 2); otherwise PC+4.
  - JR / RET: rdat1, unmodified. The architectural target is always rdat1; the RAS is a predictor only.
  - All arithmetic wraps modulo 2^ADDR_W.
- RAS operates only in cycles with pc_en=1 and flush_en=0:
  - JAL pushes pc_plus_4 at wptr; wptr <= wptr+1 mod RAS_DEPTH; count <= min(count+1, RAS_DEPTH).
  - Push when full overwrites the oldest entry (circular); count stays at RAS_DEPTH.
  - RET pops: wptr <= wptr-1 mod RAS_DEPTH; count <= count-1.
  - Pop when empty leaves pointer and count unchanged.
  - ras_top = entry[wptr-1] when count > 0, else 0. It is combinational from state.
- ras_miss:
  - Registered; asserted for exactly the cycle after an accepted RET when (count == 0) or (ras_top != rdat1) at that edge.
  - 0 in every other cycle.
  - A stalled or flushed RET produces no pulse.
- Flush (flush_en=1, RST=0): PC <= flush_vec, count <= 0, wptr <= 0, ras_miss <= 0. Stale entry contents may remain but are unobservable.
- Stall (pc_en=0, flush_en=0): PC, RAS and pointer hold; ras_miss <= 0.
- Reset mid-stream takes effect at the next edge; no partial RAS update occurs.
- No combinational path from inputs to imemaddr, ras_top, ras_empty or ras_count.

Decomposition:
- cpu_types_pkg gains:
  - pc_src_t enum {PCS_SEQ, PCS_J, PCS_JAL, PCS_BR, PCS_JR, PCS_RET}.
  - Constant PC_STEP = 4.
- pc_if is extended with the new signals (flush_en, flush_vec, br_taken, ras_*), plus a modport for this block.
- One sub-module, ras_stack:
  - Contains the entry array, write pointer, count and top-of-stack read.
  - Parameters RAS_DEPTH and ADDR_W.
  - Ports push, pop, push_data, clear, top, count, empty.
  - The PC mux, next-PC logic and ras_miss register stay in pc_ras_unit.

Test Plan:
1. Reset then SEQ for 3 cycles with PC_INIT=0 -> imemaddr 0, 4, 8, 0xC; ras_empty=1.
2. PC=0x100, BR with br_taken=1 and immediate16=0xFFFE -> next PC 0x0FC. Same with br_taken=0 -> 0x104.
3. PC=0x0040_0010, JAL with immediate26=0x10 -> PC 0x40; ras_top=0x0040_0014; ras_count=1. Then RET with rdat1=0x0040_0014 -> PC 0x0040_0014; ras_count=0; ras_miss stays 0.
4. Five JALs with RAS_DEPTH=4 (link values L1..L5) -> ras_count=4 and ras_top=L5. Four RETs return L5, L4, L3, L2 with no miss. A fifth RET -> ras_miss=1 the next cycle; count stays 0.
5. RET with rdat1 != ras_top -> PC = rdat1; ras_miss pulses for one cycle; count decrements.
6. pc_en=0 with pc_src=JAL -> PC and ras_count unchanged. flush_en=1 together with pc_en=0 and flush_vec=0x80 -> PC 0x80, ras_count 0. RST asserted together with flush_en -> PC_INIT.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: next-PC source encoding and the fetch PC step size.
`default_nettype none
package cpu_types_pkg;

  typedef enum logic [2:0] {
    PCS_SEQ = 3'd0,
    PCS_J   = 3'd1,
    PCS_JAL = 3'd2,
    PCS_BR  = 3'd3,
    PCS_JR  = 3'd4,
    PCS_RET = 3'd5
  } pc_src_t;

  localparam int PC_STEP = 4;

endpackage
`default_nettype wire

// File: rtl/pc_if.sv
// Fetch-PC bundle between decode and the fetch PC / return-address-stack unit.
`default_nettype none
interface pc_if #(
  parameter int ADDR_W    = 32,
  parameter int RAS_CNT_W = 3
);
  logic                 pc_en;
  logic                 flush_en;
  logic [ADDR_W-1:0]    flush_vec;
  logic [2:0]           pc_src;
  logic                 br_taken;
  logic [ADDR_W-1:0]    rdat1;
  logic [25:0]          immediate26;
  logic [15:0]          immediate16;
  logic [ADDR_W-1:0]    imemaddr;
  logic [ADDR_W-1:0]    pc_plus_4;
  logic [ADDR_W-1:0]    ras_top;
  logic                 ras_empty;
  logic [RAS_CNT_W-1:0] ras_count;
  logic                 ras_miss;

  modport pc_unit (
    input  pc_en, flush_en, flush_vec, pc_src, br_taken, rdat1, immediate26, immediate16,
    output imemaddr, pc_plus_4, ras_top, ras_empty, ras_count, ras_miss
  );
endinterface
`default_nettype wire

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
`default_nettype none
module ras_stack #(
  parameter int RAS_DEPTH = 4,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = $clog2(RAS_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  input  logic              clear,
  output logic [ADDR_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] entries [RAS_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  top_ptr;

  assign top_ptr = wptr - 1'b1;
  assign empty   = (count == '0);
  assign top     = empty ? '0 : entries[top_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      count <= '0;
    end else if (push) begin
      wptr <= wptr + 1'b1;
      if (count != FULL_CNT) count <= count + 1'b1;
    end else if (pop && !empty) begin
      wptr  <= top_ptr;
      count <= count - 1'b1;
    end
  end

  // Entries are not reset; they are only visible through a non-zero count.
  always_ff @(posedge clk) begin
    if (!rst && !clear && push) entries[wptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/pc_ras_unit.sv
// Fetch-stage next-PC selection with a return-address-stack predictor.
`default_nettype none
module pc_ras_unit
  import cpu_types_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] PC_INIT = '0,
  parameter int              RAS_DEPTH = 4,
  parameter int              RAS_CNT_W = $clog2(RAS_DEPTH) + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 pc_en,
  input  logic                 flush_en,
  input  logic [ADDR_W-1:0]    flush_vec,
  input  logic [2:0]           pc_src,
  input  logic                 br_taken,
  input  logic [ADDR_W-1:0]    rdat1,
  input  logic [25:0]          immediate26,
  input  logic [15:0]          immediate16,
  output logic [ADDR_W-1:0]    imemaddr,
  output logic [ADDR_W-1:0]    pc_plus_4,
  output logic [ADDR_W-1:0]    ras_top,
  output logic                 ras_empty,
  output logic [RAS_CNT_W-1:0] ras_count,
  output logic                 ras_miss
);
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_offset;
  logic              accept;
  logic              push;
  logic              pop;

  assign imemaddr      = pc;
  assign pc_plus_4     = pc + ADDR_W'(PC_STEP);
  assign branch_offset = {{(ADDR_W-18){immediate16[15]}}, immediate16, 2'b00};
  assign accept        = pc_en && !flush_en;
  assign push          = accept && (pc_src == PCS_JAL);
  assign pop           = accept && (pc_src == PCS_RET);

  generate
    if (ADDR_W > 28) begin : g_jump_region
      assign jump_target = {pc_plus_4[ADDR_W-1:28], immediate26, 2'b00};
    end else begin : g_jump_flat
      assign jump_target = {immediate26, 2'b00};
    end
  endgenerate

  always_comb begin
    next_pc = pc_plus_4;
    if (flush_en) begin
      next_pc = flush_vec;
    end else if (!pc_en) begin
      next_pc = pc;
    end else begin
      case (pc_src)
        PCS_J, PCS_JAL:  next_pc = jump_target;
        PCS_BR:          next_pc = br_taken ? (pc_plus_4 + branch_offset) : pc_plus_4;
        PCS_JR, PCS_RET: next_pc = rdat1;
        default:         next_pc = pc_plus_4;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc       <= PC_INIT;
      ras_miss <= 1'b0;
    end else begin
      pc       <= next_pc;
      ras_miss <= pop && (ras_empty || (ras_top != rdat1));
    end
  end

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .ADDR_W    (ADDR_W),
    .CNT_W     (RAS_CNT_W)
  ) u_ras (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus_4),
    .clear     (flush_en),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_pc_ras_unit.sv
// Directed self-checking bench for pc_ras_unit (ADDR_W=32, PC_INIT=0, RAS_DEPTH=4).
`default_nettype none
module tb_pc_ras_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        pc_en;
  logic        flush_en;
  logic [31:0] flush_vec;
  logic [2:0]  pc_src;
  logic        br_taken;
  logic [31:0] rdat1;
  logic [25:0] immediate26;
  logic [15:0] immediate16;
  logic [31:0] imemaddr;
  logic [31:0] pc_plus_4;
  logic [31:0] ras_top;
  logic        ras_empty;
  logic [2:0]  ras_count;
  logic        ras_miss;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] SEQ = 3'd0, JAL = 3'd2, BR = 3'd3, RET = 3'd5;

  pc_ras_unit #(.ADDR_W(32), .PC_INIT(32'h0), .RAS_DEPTH(4), .RAS_CNT_W(3)) dut (
    .CLK(clk), .RST(rst), .pc_en(pc_en), .flush_en(flush_en), .flush_vec(flush_vec),
    .pc_src(pc_src), .br_taken(br_taken), .rdat1(rdat1), .immediate26(immediate26),
    .immediate16(immediate16), .imemaddr(imemaddr), .pc_plus_4(pc_plus_4),
    .ras_top(ras_top), .ras_empty(ras_empty), .ras_count(ras_count), .ras_miss(ras_miss)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic r, input logic en, input logic fl, input logic [31:0] fv,
                     input logic [2:0] src, input logic bt, input logic [31:0] rd,
                     input logic [25:0] i26, input logic [15:0] i16);
    rst = r; pc_en = en; flush_en = fl; flush_vec = fv; pc_src = src;
    br_taken = bt; rdat1 = rd; immediate26 = i26; immediate16 = i16;
    @(posedge clk);
    #1;
  endtask

  task automatic seq();
    cyc(0, 1, 0, 0, SEQ, 0, 0, 0, 0);
  endtask

  task automatic flush(input logic [31:0] v);
    cyc(0, 1, 1, v, SEQ, 0, 0, 0, 0);
  endtask

  task automatic jal(input logic [25:0] i26);
    cyc(0, 1, 0, 0, JAL, 0, 0, i26, 0);
  endtask

  task automatic ret(input logic [31:0] rd);
    cyc(0, 1, 0, 0, RET, 0, rd, 0, 0);
  endtask

  logic [31:0] links [5];

  initial begin
    cyc(1, 0, 0, 0, SEQ, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, SEQ, 0, 0, 0, 0);
    check("reset_pc", imemaddr, 32'h0);
    check("reset_empty", 32'(ras_empty), 32'h1);
    check("reset_count", 32'(ras_count), 32'h0);
    check("reset_top", ras_top, 32'h0);
    check("reset_miss", 32'(ras_miss), 32'h0);
    check("reset_pc4", pc_plus_4, 32'h4);

    seq(); check("seq1", imemaddr, 32'h4);
    seq(); check("seq2", imemaddr, 32'h8);
    seq(); check("seq3", imemaddr, 32'hC);
    check("seq_empty", 32'(ras_empty), 32'h1);

    flush(32'h100); check("flush_pc", imemaddr, 32'h100);
    cyc(0, 1, 0, 0, BR, 1, 0, 0, 16'hFFFE); check("br_taken_neg", imemaddr, 32'h0FC);
    flush(32'h100);
    cyc(0, 1, 0, 0, BR, 0, 0, 0, 16'hFFFE); check("br_not_taken", imemaddr, 32'h104);
    cyc(0, 1, 0, 0, BR, 1, 0, 0, 16'h0003); check("br_taken_pos", imemaddr, 32'h114);

    flush(32'hFFFF_FFFC);
    check("pc4_wrap", pc_plus_4, 32'h0);

    flush(32'h0040_0010);
    jal(26'h10);
    check("jal_pc", imemaddr, 32'h40);
    check("jal_top", ras_top, 32'h0040_0014);
    check("jal_count", 32'(ras_count), 32'h1);
    ret(32'h0040_0014);
    check("ret_pc", imemaddr, 32'h0040_0014);
    check("ret_count", 32'(ras_count), 32'h0);
    check("ret_hit_miss", 32'(ras_miss), 32'h0);

    // Five calls into a 4-deep stack: the oldest link (L1) is overwritten.
    links[0] = 32'h0040_0018; links[1] = 32'h404; links[2] = 32'h804;
    links[3] = 32'hC04;       links[4] = 32'h1004;
    for (int k = 1; k <= 5; k++) begin
      jal(26'(k * 32'h100));
      check("jal_chain_pc", imemaddr, 32'(k * 32'h400));
      check("jal_chain_top", ras_top, links[k-1]);
    end
    check("full_count", 32'(ras_count), 32'h4);
    for (int k = 4; k >= 1; k--) begin
      ret(links[k]);
      check("pop_pc", imemaddr, links[k]);
      check("pop_miss", 32'(ras_miss), 32'h0);
      check("pop_count", 32'(ras_count), 32'(k - 1));
      check("pop_top", ras_top, (k > 1) ? links[k-1] : 32'h0);
    end
    ret(32'h2000);
    check("empty_ret_pc", imemaddr, 32'h2000);
    check("empty_ret_miss", 32'(ras_miss), 32'h1);
    check("empty_ret_count", 32'(ras_count), 32'h0);
    seq();
    check("miss_one_cycle", 32'(ras_miss), 32'h0);
    check("after_miss_pc", imemaddr, 32'h2004);

    jal(26'h10);
    check("jal2_top", ras_top, 32'h2008);
    ret(32'h3000);
    check("wrong_ret_pc", imemaddr, 32'h3000);
    check("wrong_ret_miss", 32'(ras_miss), 32'h1);
    check("wrong_ret_count", 32'(ras_count), 32'h0);
    seq();
    check("wrong_miss_clear", 32'(ras_miss), 32'h0);

    jal(26'h20);
    check("jal3_pc", imemaddr, 32'h80);
    check("jal3_count", 32'(ras_count), 32'h1);
    cyc(0, 0, 0, 0, JAL, 0, 0, 26'h55, 0);
    check("stall_pc", imemaddr, 32'h80);
    check("stall_count", 32'(ras_count), 32'h1);
    cyc(0, 0, 0, 0, RET, 0, 32'h1234, 0, 0);
    check("stall_ret_pc", imemaddr, 32'h80);
    check("stall_ret_miss", 32'(ras_miss), 32'h0);
    check("stall_ret_count", 32'(ras_count), 32'h1);
    seq();
    check("seq_84", imemaddr, 32'h84);
    cyc(0, 0, 1, 32'h80, RET, 0, 32'h1234, 0, 0);
    check("flush_stall_pc", imemaddr, 32'h80);
    check("flush_stall_count", 32'(ras_count), 32'h0);
    check("flush_ret_miss", 32'(ras_miss), 32'h0);
    jal(26'h30);
    check("pre_rst_count", 32'(ras_count), 32'h1);
    cyc(1, 1, 1, 32'h500, JAL, 0, 0, 26'h40, 0);
    check("rst_flush_pc", imemaddr, 32'h0);
    check("rst_flush_count", 32'(ras_count), 32'h0);
    check("rst_flush_empty", 32'(ras_empty), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
